// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable depth and wait states.
//
// Parameters:
//   P_DEPTH  number of 32-bit words (power of two, 16..4096)
//   P_WAIT   wait states per OKAY transfer (0..7)
//
// Ports:
//   HCLK, HRESET          rising-edge clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,  address-phase controls; a transfer is accepted when
//   HWRITE, HSIZE         HSEL & HREADY & HTRANS[1]
//   HBURST, HPROT         ignored
//   HWDATA                write data, sampled in the LAST data-phase cycle
//   HREADY                bus-level ready from the multiplexor
//   HRDATA                read data, valid in the LAST cycle of a read
//   HRESP                 OKAY (00) or ERROR (01)
//   HREADYout             this slave's ready
module ahb_sram_slave #(
  parameter int unsigned P_DEPTH = 256,
  parameter int unsigned P_WAIT  = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYout
);

  localparam int unsigned AddrW    = $clog2(P_DEPTH);
  localparam logic [2:0]  WaitInit = (P_WAIT > 0) ? 3'(P_WAIT - 1) : 3'd0;

  typedef enum logic [2:0] {StIdle, StWait, StLast, StErr1, StErr2} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [AddrW+1:0] addr_q;
  logic             write_q;
  logic [1:0]       size_q;
  logic [31:0]      hrdata_q;

  logic [31:0]      mem [P_DEPTH];

  logic             take;
  logic             req_err;
  logic             mem_we;
  logic             rd_load;
  logic             fwd;
  logic [AddrW-1:0] wr_idx;
  logic [AddrW-1:0] rd_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_word;
  logic [31:0]      rd_word;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT};

  // Little-endian byte-lane enables for a data-phase transfer.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    unique case (size)
      2'd0:    m = 4'b0001 << a;
      2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // New transfers are only taken when the slave is not stalling the bus.
  assign take = HSEL && HREADY && HTRANS[1] &&
                ((state_q == StIdle) || (state_q == StLast) || (state_q == StErr2));

  always_comb begin
    req_err = 1'b0;
    if (HSIZE > 3'd2) req_err = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0]) req_err = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) req_err = 1'b1;
    if ({2'b00, HADDR[31:2]} >= P_DEPTH) req_err = 1'b1;
  end

  // Next state and per-state bus outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYout = 1'b1;
    HRESP     = 2'b00;
    unique case (state_q)
      StIdle, StLast, StErr2: begin
        if (state_q == StErr2) HRESP = 2'b01;
        if (take) begin
          if (req_err) begin
            state_d = StErr1;
          end else if (P_WAIT > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StLast;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        HREADYout = 1'b0;
        if (cnt_q == 3'd0) begin
          state_d = StLast;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StErr1: begin
        HREADYout = 1'b0;
        HRESP     = 2'b01;
        state_d   = StErr2;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write path: merge HWDATA into the addressed word at the end of LAST.
  assign wr_idx = addr_q[AddrW+1:2];
  assign wr_be  = lane_mask(size_q, addr_q[1:0]);
  assign mem_we = (state_q == StLast) && write_q;

  always_comb begin
    wr_word = mem[wr_idx];
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // Read path: HRDATA is loaded at the edge entering LAST. From WAIT the address is
  // the latched one; on a zero-wait accept it comes straight off the bus, and a write
  // committing at that same edge to the same word is forwarded.
  assign rd_idx  = (state_q == StWait) ? addr_q[AddrW+1:2] : HADDR[AddrW+1:2];
  assign fwd     = mem_we && (rd_idx == wr_idx);
  assign rd_word = fwd ? wr_word : mem[rd_idx];
  assign rd_load = (state_d == StLast) && ((state_q == StWait) ? !write_q : !HWRITE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      hrdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        addr_q  <= HADDR[AddrW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
      if (rd_load) hrdata_q <= rd_word;
    end
  end

  // Memory is never cleared; reset only suppresses an in-flight write.
  always_ff @(posedge HCLK) begin
    if (mem_we && !HRESET) mem[wr_idx] <= wr_word;
  end

  assign HRDATA = hrdata_q;

endmodule
